// File: rtl/top_sweep_pkg.sv
// Shared widths, state encoding and nibble-replication helper for the
// SW->LED sweep sequencer.
package top_sweep_pkg;

  localparam int DUT_W = 12;
  localparam int NIB_W = 4;
  localparam int SIG_W = 16;
  localparam int REP   = 3;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_DRIVE = 2'd1;
  localparam logic [1:0] ST_FIN   = 2'd2;

  typedef enum logic [1:0] {
    S_IDLE  = ST_IDLE,
    S_DRIVE = ST_DRIVE,
    S_FIN   = ST_FIN
  } state_t;

  function automatic logic [DUT_W-1:0] rep_nib(input logic [NIB_W-1:0] x);
    return {REP{x}};
  endfunction

endpackage

// File: rtl/top_sweep_ctrl_timer.sv
// Hold timer: counts enabled cycles and flags the last cycle of each
// HOLD_CYCLES-long hold window, then wraps to zero.
module sweep_hold_timer
  import top_sweep_pkg::*;
#(
  parameter int HOLD_CYCLES = 20
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic tick
);

  localparam int CW = $clog2(HOLD_CYCLES + 1);
  localparam logic [CW-1:0] LAST = CW'(HOLD_CYCLES - 1);

  logic [CW-1:0] cnt;

  assign tick = en && (cnt == LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= tick ? '0 : cnt + 1'b1;
    end
  end

endmodule

// File: rtl/top_sweep_ctrl.sv
// Nibble-sweep sequencer for the SW->LED lab datapath, with manual pass-through.
// Optional LED signature register enabled by `define TOP_SWEEP_SIGNATURE_EN.
//
// state   | meaning
// S_IDLE  | pass-through (mode=0) or waiting for start (mode=1)
// S_DRIVE | holding {X,X,X} on sw_dut, sampling led_dut at end of hold
// S_FIN   | one-cycle done pulse, then back to idle
module top_sweep_ctrl
  import top_sweep_pkg::*;
#(
  parameter int         HOLD_CYCLES = 20,
  parameter logic [3:0] START_VAL   = 4'hF,
  parameter logic [3:0] END_VAL     = 4'h0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              mode,
  input  logic [DUT_W-1:0]  sw_in,
  input  logic [DUT_W-1:0]  led_dut,
  output logic [DUT_W-1:0]  sw_dut,
  output logic              busy,
  output logic              done,
  output logic [NIB_W-1:0]  step,
  output logic [DUT_W-1:0]  led_cap,
  output logic [SIG_W-1:0]  sig
);

  localparam logic DESC = START_VAL > END_VAL;

  state_t           state, state_nxt;
  logic             accept;
  logic             tick;
  logic             last;
  logic [NIB_W-1:0] step_nxt;

  assign accept   = (state == S_IDLE) && start && mode;
  assign last     = (step == END_VAL);
  assign step_nxt = DESC ? step - 1'b1 : step + 1'b1;

  sweep_hold_timer #(.HOLD_CYCLES(HOLD_CYCLES)) u_timer (
    .clk  (clk),
    .rst  (rst),
    .clr  (accept),
    .en   (state == S_DRIVE),
    .tick (tick)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (accept) state_nxt = S_DRIVE;
      S_DRIVE: if (tick && last) state_nxt = S_FIN;
      S_FIN:   state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sw_dut  <= '0;
      step    <= '0;
      led_cap <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (accept) begin
            step   <= START_VAL;
            sw_dut <= rep_nib(START_VAL);
            busy   <= 1'b1;
          end else if (!mode) begin
            sw_dut <= sw_in;
          end
        end
        S_DRIVE: begin
          if (tick) begin
            led_cap <= led_dut;
            if (last) begin
              busy <= 1'b0;
              done <= 1'b1;
            end else begin
              step   <= step_nxt;
              sw_dut <= rep_nib(step_nxt);
            end
          end
        end
        default: ;
      endcase
    end
  end

`ifdef TOP_SWEEP_SIGNATURE_EN
  logic [SIG_W-1:0] sig_q;

  // Rotate-left then fold in the sample; survives FIN until the next start.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sig_q <= '0;
    end else if (accept) begin
      sig_q <= '0;
    end else if ((state == S_DRIVE) && tick) begin
      sig_q <= {sig_q[SIG_W-2:0], sig_q[SIG_W-1]} ^ {{(SIG_W-DUT_W){1'b0}}, led_dut};
    end
  end

  assign sig = sig_q;
`else
  assign sig = '0;
`endif

endmodule

// File: tb/tb_top_sweep_ctrl.sv
// Self-checking bench for top_sweep_ctrl: table vectors, a cycle-level
// reference model under random stimulus, and hand-written corner sequences.
module tb_top_sweep_ctrl;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // instance A: default parameters
  logic        start_a = 0, mode_a = 0;
  logic [11:0] sw_in_a = 0, led_r_a = 0, led_a;
  bit          lb_a = 0;
  logic [11:0] sw_dut_a, led_cap_a;
  logic        busy_a, done_a;
  logic [3:0]  step_a;
  logic [15:0] sig_a;
  assign led_a = lb_a ? sw_dut_a : led_r_a;

  // instance B: 1 -> 0, hold 2, loopback
  logic        start_b = 0, mode_b = 1;
  logic [11:0] sw_in_b = 0, led_b;
  logic [11:0] sw_dut_b, led_cap_b;
  logic        busy_b, done_b;
  logic [3:0]  step_b;
  logic [15:0] sig_b;
  assign led_b = sw_dut_b;

  // instance C: 7 -> 7, hold 1, loopback
  logic        start_c = 0, mode_c = 1;
  logic [11:0] sw_in_c = 0, led_c;
  logic [11:0] sw_dut_c, led_cap_c;
  logic        busy_c, done_c;
  logic [3:0]  step_c;
  logic [15:0] sig_c;
  assign led_c = sw_dut_c;

  top_sweep_ctrl u_a (
    .clk(clk), .rst(rst), .start(start_a), .mode(mode_a), .sw_in(sw_in_a),
    .led_dut(led_a), .sw_dut(sw_dut_a), .busy(busy_a), .done(done_a),
    .step(step_a), .led_cap(led_cap_a), .sig(sig_a)
  );

  top_sweep_ctrl #(.HOLD_CYCLES(2), .START_VAL(4'h1), .END_VAL(4'h0)) u_b (
    .clk(clk), .rst(rst), .start(start_b), .mode(mode_b), .sw_in(sw_in_b),
    .led_dut(led_b), .sw_dut(sw_dut_b), .busy(busy_b), .done(done_b),
    .step(step_b), .led_cap(led_cap_b), .sig(sig_b)
  );

  top_sweep_ctrl #(.HOLD_CYCLES(1), .START_VAL(4'h7), .END_VAL(4'h7)) u_c (
    .clk(clk), .rst(rst), .start(start_c), .mode(mode_c), .sw_in(sw_in_c),
    .led_dut(led_c), .sw_dut(sw_dut_c), .busy(busy_c), .done(done_c),
    .step(step_c), .led_cap(led_cap_c), .sig(sig_c)
  );

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: phase 0 idle, 1 sweeping, 2 done pulse.
  // Progress tracked as elapsed cycles t since the accepting edge.
  typedef struct {
    int          h;
    int          s;
    int          e;
    int          phase;
    int          t;
    logic [11:0] sw;
    logic [11:0] cap;
    logic [3:0]  step;
    logic [15:0] sig;
  } mdl_t;

  function automatic mdl_t mreset(input int h, input int s, input int e);
    mdl_t m;
    m.h = h; m.s = s; m.e = e;
    m.phase = 0; m.t = 0;
    m.sw = '0; m.cap = '0; m.step = '0; m.sig = '0;
    return m;
  endfunction

  function automatic mdl_t mstep(input mdl_t mi, input logic st, input logic md,
                                 input logic [11:0] swi, input logic [11:0] led);
    mdl_t m;
    int n, dir, i;
    m = mi;
    n   = (m.s > m.e ? m.s - m.e : m.e - m.s) + 1;
    dir = (m.s > m.e) ? -1 : 1;
    case (m.phase)
      0: begin
        if (!md) m.sw = swi;
        if (st && md) begin
          m.phase = 1;
          m.t     = 0;
          m.step  = 4'(m.s);
          m.sw    = {3{4'(m.s)}};
          m.sig   = '0;
        end
      end
      1: begin
        m.t++;
        if (m.t % m.h == 0) begin
          m.cap = led;
          m.sig = {m.sig[14:0], m.sig[15]} ^ {4'h0, led};
          i = m.t / m.h;
          if (i == n) begin
            m.phase = 2;
          end else begin
            m.step = 4'(m.s + dir * i);
            m.sw   = {3{m.step}};
          end
        end
      end
      default: m.phase = 0;
    endcase
    return m;
  endfunction

  mdl_t ma;

  task automatic check_a();
    chk("a_sw_dut",  {4'h0, sw_dut_a},  {4'h0, ma.sw});
    chk("a_led_cap", {4'h0, led_cap_a}, {4'h0, ma.cap});
    chk("a_step",    {12'h0, step_a},   {12'h0, ma.step});
    chk("a_busy",    {15'h0, busy_a},   {15'h0, (ma.phase == 1)});
    chk("a_done",    {15'h0, done_a},   {15'h0, (ma.phase == 2)});
`ifdef TOP_SWEEP_SIGNATURE_EN
    chk("a_sig", sig_a, ma.sig);
`else
    chk("a_sig", sig_a, 16'h0000);
`endif
  endtask

  task automatic tick_a(input logic st, input logic md, input logic [11:0] swi,
                        input logic [11:0] ledr, input bit lb);
    logic [11:0] led_used;
    start_a = st; mode_a = md; sw_in_a = swi; led_r_a = ledr; lb_a = lb;
    led_used = lb ? ma.sw : ledr;
    @(posedge clk);
    ma = mstep(ma, st, md, swi, led_used);
    #1;
    check_a();
  endtask

  typedef struct {
    logic        mode;
    logic        start;
    logic [11:0] swi;
    logic [11:0] exp_sw;
    logic        exp_busy;
  } vec_t;

  vec_t tv[6];
  int   dc;
  logic [15:0] exp_sig1, exp_sig2;

  initial begin
    tv[0] = '{1'b0, 1'b0, 12'hA5C, 12'hA5C, 1'b0};
    tv[1] = '{1'b0, 1'b1, 12'hA5C, 12'hA5C, 1'b0};
    tv[2] = '{1'b0, 1'b1, 12'h123, 12'h123, 1'b0};
    tv[3] = '{1'b1, 1'b0, 12'hFFF, 12'h123, 1'b0};
    tv[4] = '{1'b0, 1'b0, 12'hFFF, 12'hFFF, 1'b0};
    tv[5] = '{1'b1, 1'b0, 12'h000, 12'hFFF, 1'b0};
`ifdef TOP_SWEEP_SIGNATURE_EN
    exp_sig1 = 16'h0111; exp_sig2 = 16'h0222;
`else
    exp_sig1 = 16'h0000; exp_sig2 = 16'h0000;
`endif

    // reset state
    ma = mreset(20, 15, 0);
    repeat (2) @(posedge clk);
    #1;
    check_a();
    rst = 1'b0;

    // manual pass-through and mode=1 hold
    for (int i = 0; i < 6; i++) begin
      tick_a(tv[i].start, tv[i].mode, tv[i].swi, 12'h0, 1'b0);
      chk("tv_sw_dut", {4'h0, sw_dut_a}, {4'h0, tv[i].exp_sw});
      chk("tv_busy",   {15'h0, busy_a},  {15'h0, tv[i].exp_busy});
    end

    // full loopback sweep with default parameters
    dc = 0;
    for (int c = 0; c < 330; c++) begin
      tick_a(c == 0, 1'b1, 12'h0, 12'h0, 1'b1);
      if (done_a) dc++;
      if (c == 0) begin
        chk("lb_first_sw", {4'h0, sw_dut_a}, 16'h0FFF);
        chk("lb_first_step", {12'h0, step_a}, 16'h000F);
        chk("lb_first_busy", {15'h0, busy_a}, 16'h0001);
      end
      if (c == 320) begin
        chk("lb_last_cap", {4'h0, led_cap_a}, 16'h0000);
        chk("lb_last_done", {15'h0, done_a}, 16'h0001);
        chk("lb_last_busy", {15'h0, busy_a}, 16'h0000);
      end
      if (c == 321) begin
        chk("lb_after_done", {15'h0, done_a}, 16'h0000);
        chk("lb_after_busy", {15'h0, busy_a}, 16'h0000);
      end
    end
    chk("lb_done_pulses", 16'(dc), 16'd1);

    // ignored requests: random start/mode during the sweep
    dc = 0;
    for (int c = 0; c < 330; c++) begin
      tick_a((c == 0) ? 1'b1 : 1'($urandom_range(0, 1)),
             (c == 0) ? 1'b1 : 1'($urandom_range(0, 1)),
             12'($urandom), 12'($urandom), 1'b0);
      if (done_a) dc++;
    end
    chk("ign_done_pulses", 16'(dc), 16'd1);

    // long random run
    for (int c = 0; c < 1500; c++) begin
      tick_a(($urandom_range(0, 39) == 0), ($urandom_range(0, 3) != 0),
             12'($urandom), 12'($urandom), 1'($urandom_range(0, 1)));
    end

    // reset mid-sweep
    #1 rst = 1'b1;
    ma = mreset(20, 15, 0);
    @(posedge clk);
    #1 rst = 1'b0;
    tick_a(1'b1, 1'b1, 12'h0, 12'h0, 1'b1);
    for (int c = 1; c < 50; c++) tick_a(1'b0, 1'b1, 12'h0, 12'h0, 1'b1);
    chk("rst_pre_busy", {15'h0, busy_a}, 16'h0001);
    rst = 1'b1;
    ma = mreset(20, 15, 0);
    #1;
    check_a();
    @(posedge clk);
    #1 rst = 1'b0;
    tick_a(1'b1, 1'b1, 12'h0, 12'h0, 1'b1);
    chk("restart_step", {12'h0, step_a}, 16'h000F);
    chk("restart_sw", {4'h0, sw_dut_a}, 16'h0FFF);
    for (int c = 1; c < 25; c++) tick_a(1'b0, 1'b1, 12'h0, 12'h0, 1'b1);

    // small sweep 1 -> 0, hold 2
    start_b = 1'b1;
    @(posedge clk);
    #1 start_b = 1'b0;
    chk("b_sw0", {4'h0, sw_dut_b}, 16'h0111);
    chk("b_busy0", {15'h0, busy_b}, 16'h0001);
    chk("b_sig0", sig_b, 16'h0000);
    repeat (2) @(posedge clk);
    #1;
    chk("b_cap1", {4'h0, led_cap_b}, 16'h0111);
    chk("b_sig1", sig_b, exp_sig1);
    chk("b_sw1", {4'h0, sw_dut_b}, 16'h0000);
    chk("b_done1", {15'h0, done_b}, 16'h0000);
    repeat (2) @(posedge clk);
    #1;
    chk("b_cap2", {4'h0, led_cap_b}, 16'h0000);
    chk("b_sig2", sig_b, exp_sig2);
    chk("b_done2", {15'h0, done_b}, 16'h0001);
    chk("b_busy2", {15'h0, busy_b}, 16'h0000);
    @(posedge clk);
    #1;
    chk("b_done3", {15'h0, done_b}, 16'h0000);
    chk("b_sig3", sig_b, exp_sig2);

    // single step 7 -> 7, hold 1
    start_c = 1'b1;
    @(posedge clk);
    #1 start_c = 1'b0;
    chk("c_sw0", {4'h0, sw_dut_c}, 16'h0777);
    chk("c_step0", {12'h0, step_c}, 16'h0007);
    chk("c_busy0", {15'h0, busy_c}, 16'h0001);
    chk("c_done0", {15'h0, done_c}, 16'h0000);
    @(posedge clk);
    #1;
    chk("c_cap1", {4'h0, led_cap_c}, 16'h0777);
    chk("c_done1", {15'h0, done_c}, 16'h0001);
    chk("c_busy1", {15'h0, busy_c}, 16'h0000);
    @(posedge clk);
    #1;
    chk("c_done2", {15'h0, done_c}, 16'h0000);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/top_sweep_ctrl.md
Name: top_sweep_ctrl

Overview:
- Sequencer for the 12-bit SW→LED lab datapath (TOP). It replaces manual switch toggling with an automatic nibble sweep.
- Drives SW_DUT with a 4-bit pattern replicated three times ({X,X,X}) and holds each value for HOLD_CYCLES clocks.
- Samples LED_DUT at the end of each hold and reports progress.
- In manual mode it passes the board switches through to TOP.

Parameters:
- HOLD_CYCLES, 20, clocks each pattern is held before LED sampling; must be ≥1.
- START_VAL, 4'hF, first nibble of the sweep.
- END_VAL, 4'h0, last nibble of the sweep.

Ports:
- CLK  in  1  system clock, rising edge.
- RST  in  1  asynchronous reset, active-high.
- START  in  1  sweep request; acted on only in IDLE with MODE=1.
- MODE  in  1  0 = manual pass-through, 1 = sweep.
- SW_IN  in  12  board switches.
- LED_DUT  in  12  LED outputs of TOP.
- SW_DUT  out  12  switch inputs to TOP, registered.
- BUSY  out  1  high while sweeping.
- DONE  out  1  one-cycle pulse after the last sample.
- STEP  out  4  current nibble X.
- LED_CAP  out  12  most recent LED_DUT sample.
- SIG  out  16  LED signature (see Optional Feature).

Behaviour:
- Reset (async, RST=1), any time including mid-sweep:
  - state=IDLE.
  - SW_DUT, LED_CAP, SIG = 0; STEP=0; BUSY=0; DONE=0.
  - Hold counter=0.
- States: IDLE, DRIVE, FIN.
- IDLE:
  - MODE=0: SW_DUT<=SW_IN each edge (1-cycle latency).
  - MODE=1: SW_DUT holds its last value.
  - START=1 and MODE=1 at edge k: go to DRIVE; X<=START_VAL; SW_DUT<={START_VAL x3}; counter<=0; BUSY=1 from edge k. SIG is cleared when the feature is compiled in.
- DRIVE: counter increments each edge. When counter==HOLD_CYCLES-1:
  - LED_CAP<=LED_DUT on that edge.
  - If X==END_VAL: go to FIN, BUSY<=0, DONE<=1.
  - Else: X steps toward END_VAL (decrement if START_VAL>END_VAL, else increment); SW_DUT<={Xnext x3}; counter<=0.
- FIN: DONE=1 for exactly one cycle, then IDLE.
- Timing:
  - Step count N = |START_VAL−END_VAL|+1.
  - Sample i (0-based) lands at edge k+(i+1)·HOLD_CYCLES.
  - DONE is high in the cycle after edge k+N·HOLD_CYCLES.
- Ignored inputs:
  - START while BUSY or in FIN.
  - MODE changes during DRIVE/FIN; MODE is re-evaluated in IDLE only.
- Boundary cases:
  - START_VAL==END_VAL: single step, N=1.
  - HOLD_CYCLES=1: a new pattern and a sample every cycle.
- Counter width is $clog2(HOLD_CYCLES+1). Nibble arithmetic never wraps, because the step stops at END_VAL.
- STEP mirrors X and equals 0 after reset.

Optional Feature:
- Macro: TOP_SWEEP_SIGNATURE_EN.
- Defined:
  - On each sample, SIG<={SIG[14:0],SIG[15]} ^ {4'h0,LED_DUT}.
  - SIG is cleared on accepted START and holds its value after FIN.
- Undefined: the SIG port remains and is tied to 16'h0000; no signature logic is built.

Decomposition:
- Package top_sweep_pkg:
  - DUT_W=12, NIB_W=4, SIG_W=16.
  - State encoding localparams ST_IDLE=2'd0, ST_DRIVE=2'd1, ST_FIN=2'd2.
  - Replication helper constant REP=3.
- Sub-module sweep_hold_timer:
  - Parameter HOLD_CYCLES; inputs CLK, RST, clr, en; output tick at counter==HOLD_CYCLES-1.
  - The FSM and datapath stay in top_sweep_ctrl.

Test Plan:
- Reset mid-sweep: default params, START, then RST at cycle 50 → all outputs 0 immediately (async), IDLE; a new START restarts at STEP=F.
- Loopback sweep: LED_DUT=SW_DUT, defaults → 16 samples; SW_DUT=0xFFF at edge k+1, LED_CAP=0x000 after edge k+320; DONE pulses for one cycle in the next cycle; BUSY low after.
- Small sweep with signature: START_VAL=1, END_VAL=0, HOLD_CYCLES=2, loopback, macro defined → LED_CAP 0x111 then 0x000; SIG=0x0111 then 0x0222; without the macro, SIG=0x0000 throughout.
- Manual mode: MODE=0, SW_IN=0xA5C → SW_DUT=0xA5C one edge later; START ignored, BUSY stays 0.
- Ignored requests: START pulsed during DRIVE and MODE toggled to 0 mid-sweep → sweep completes unchanged with exactly 16 samples and one DONE pulse.
- Single step: START_VAL=END_VAL=7, HOLD_CYCLES=1 → SW_DUT=0x777, one sample, DONE in the second cycle after START.
